// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          PC_W         = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetched {instr, pc}; clear wins over push/pop in the same cycle.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t dout,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Empty FIFO presents zeros rather than a stale popped entry.
    assign dout  = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues one-cycle-latency ROM reads under a
// credit limit, and hands words to decode through a 2-entry valid/ready buffer.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          ROM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    input  logic              instr_ready
);

    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;

    logic         pop;
    logic         push;
    logic         issue;
    logic [1:0]   count;
    logic [2:0]   committed;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign pop = instr_valid && instr_ready;

    // Entries that will occupy the buffer once this cycle's pop and the
    // returning response settle; a new request needs a free slot among them.
    assign committed = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = !rst && !redirect && (committed < 3'd2);

    // A response returning during a redirect belongs to the old path.
    assign push             = inflight_q && !redirect;
    assign push_entry.instr = rom_data;
    assign push_entry.pc    = inflight_pc_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~32'd3;
        end else if (issue) begin
            pc_d          = pc_q + PC_STEP;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_skid_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    assign rom_en      = issue;
    assign rom_addr    = issue ? pc_q[ROM_AW+1:2] : '0;
    assign instr_valid = (count != 2'd0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected PCs queued as stimulus is driven,
// checked against each transfer; a second instance exercises PC wrap.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        w_rom_en;
    logic [9:0]  w_rom_addr;
    logic [31:0] w_rom_data;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    int          tests;
    int          fails;
    int          xfers;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        case (a)
            10'd0:   rom_word = 32'h2008_0005;
            10'd1:   rom_word = 32'h2009_0003;
            10'd2:   rom_word = 32'h0109_5020;
            10'd3:   rom_word = 32'hAC0A_0000;
            10'd5:   rom_word = 32'h0000_0000;
            default: rom_word = {16'hC0DE, 6'd0, a};
        endcase
    endfunction

    inst_fetch #(.RESET_PC(32'h0000_0000), .ROM_AW(10)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .ROM_AW(10)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (w_rom_en),
        .rom_addr    (w_rom_addr),
        .rom_data    (w_rom_data),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .instr_valid (w_instr_valid),
        .instr       (w_instr),
        .instr_pc    (w_instr_pc),
        .instr_ready (1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rom_en)   rom_data   <= rom_word(rom_addr);
        if (w_rom_en) w_rom_data <= rom_word(w_rom_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: settle, score any transfer, then advance to just past the edge.
    task automatic cycle();
        logic [31:0] e;
        #1;
        if (instr_valid && instr_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_underflow: observed pc %h expected no transfer", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_pc", instr_pc, e);
                chk("xfer_instr", instr, rom_word(e[11:2]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        int          x0;
        tests       = 0;
        fails       = 0;
        xfers       = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
        chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_w_rom_addr", {22'd0, w_rom_addr}, 32'd0);

        // Streaming from reset with ready held high.
        rst         = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        #1;
        chk("first_rom_en", {31'd0, rom_en}, 32'd1);
        chk("first_rom_addr", {22'd0, rom_addr}, 32'd0);
        chk("first_valid", {31'd0, instr_valid}, 32'd0);
        chk("wrap_addr0", {22'd0, w_rom_addr}, 32'h3FE);
        cycle();
        chk("lat_valid_t1", {31'd0, instr_valid}, 32'd0);
        chk("wrap_addr1", {22'd0, w_rom_addr}, 32'h3FF);
        cycle();
        chk("lat_valid_t2", {31'd0, instr_valid}, 32'd1);
        chk("lat_pc_t2", instr_pc, 32'h0);
        chk("wrap_addr2", {22'd0, w_rom_addr}, 32'h000);
        chk("wrap_pc0", w_instr_pc, 32'hFFFF_FFF8);
        cycle();
        chk("wrap_pc1", w_instr_pc, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc2", w_instr_pc, 32'h0000_0000);
        chk("wrap_instr2", w_instr, 32'h2008_0005);
        cycle();
        cycle();
        chk("stream_xfers", 32'(xfers), 32'd4);

        // Back-pressure for 5 cycles.
        instr_ready = 1'b0;
        #1;
        held = instr;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rom_en", {31'd0, rom_en}, 32'd0);
            chk("stall_instr", instr, held);
            chk("stall_pc", instr_pc, 32'h10);
            cycle();
        end
        instr_ready = 1'b1;
        #1;
        chk("resume_rom_en", {31'd0, rom_en}, 32'd1);
        chk("resume_rom_addr", {22'd0, rom_addr}, 32'd6);
        x0 = xfers;
        repeat (4) cycle();
        chk("resume_xfers", 32'(xfers - x0), 32'd4);

        // Redirect with a request in flight and a transfer in the same cycle.
        exp_q.push_back(32'h20);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        #1;
        chk("redir_rom_en", {31'd0, rom_en}, 32'd0);
        cycle();
        redirect = 1'b0;
        exp_q.push_back(32'h40);
        #1;
        chk("redir_t1_rom_en", {31'd0, rom_en}, 32'd1);
        chk("redir_t1_addr", {22'd0, rom_addr}, 32'h10);
        chk("redir_t1_valid", {31'd0, instr_valid}, 32'd0);
        cycle();
        chk("redir_t2_valid", {31'd0, instr_valid}, 32'd0);
        cycle();
        chk("redir_t3_valid", {31'd0, instr_valid}, 32'd1);
        chk("redir_t3_pc", instr_pc, 32'h40);

        // Fill both entries, then redirect while transferring the head.
        instr_ready = 1'b0;
        cycle();
        cycle();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        chk("redir2_rom_en", {31'd0, rom_en}, 32'd0);
        cycle();
        redirect = 1'b0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        repeat (5) cycle();
        instr_ready = 1'b0;
        #1;
        chk("redir2_drain", 32'(exp_q.size()), 32'd0);

        // One-cycle reset mid-stream.
        rst = 1'b1;
        #1;
        chk("mrst_rom_en", {31'd0, rom_en}, 32'd0);
        @(posedge clk);
        #1;
        chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mrst_instr", instr, 32'h0);
        chk("mrst_pc", instr_pc, 32'h0);
        chk("mrst_rom_addr", {22'd0, rom_addr}, 32'd0);
        rst         = 1'b0;
        instr_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        #1;
        chk("mrst_restart_en", {31'd0, rom_en}, 32'd1);
        chk("mrst_restart_addr", {22'd0, rom_addr}, 32'd0);
        repeat (4) cycle();
        instr_ready = 1'b0;
        #1;
        chk("mrst_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
